alu_datapath: RTL

//  Arithmetic datapath of the sequential ALU; sits directly downstream of control_unit.

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_add_sub.sv | 23 ++
 rtl/alu_datapath.sv | 132 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op encodings, adder select values
// and the iteration counter width helper.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_e;

    localparam logic ADD_SEL = 1'b0;
    localparam logic SUB_SEL = 1'b1;

    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/alu_add_sub.sv
// Combinational WIDTH-bit adder/subtractor with two's-complement signed overflow.
module alu_add_sub
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             ovf
);

    logic [WIDTH-1:0] b_eff_s;

    // Subtraction is a + ~b + 1; overflow when equal-signed operands give a differently signed sum.
    always_comb begin
        b_eff_s = (sub == SUB_SEL) ? ~b : b;
        sum     = a + b_eff_s + {{(WIDTH-1){1'b0}}, sub};
        ovf     = (a[WIDTH-1] == b_eff_s[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end

endmodule

// File: rtl/alu_datapath.sv
// Arithmetic datapath of the sequential ALU (A, Q, M, Q[-1], counter, result).
// Optional zf/vf status flags are built when ALU_DP_FLAGS_EN is defined.
module alu_datapath
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   inbus,
    input  logic               c0,
    input  logic               c1,
    input  logic               c2,
    input  logic               c3,
    input  logic               c4,
    input  logic               c5,
    input  logic               c6,
    input  logic               c7,
    output logic               q0,
    output logic               qm1,
    output logic               a7,
    output logic               cnt_done,
`ifdef ALU_DP_FLAGS_EN
    output logic               zf,
    output logic               vf,
`endif
    output logic [2*WIDTH-1:0] outbus
);

    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [WIDTH-1:0] a_r, q_r, m_r;
    logic             qm1_r;
    logic [CW-1:0]    cnt_r;

    logic [WIDTH-1:0] sum_s, a_pre_s, a_nxt_s, q_nxt_s;
    logic             ovf_s, qm1_nxt_s;
    logic [CW-1:0]    cnt_nxt_s;
    op_e              op_s;

    assign op_s = op_e'(op);

    alu_add_sub #(.WIDTH(WIDTH)) u_add_sub (
        .a   (a_r),
        .b   (m_r),
        .sub (c3),
        .sum (sum_s),
        .ovf (ovf_s)
    );

    // Add/sub result feeds the shifter so c2 and c4 together add then shift in one cycle.
    always_comb begin
        a_pre_s   = c2 ? sum_s : a_r;
        a_nxt_s   = a_pre_s;
        q_nxt_s   = q_r;
        qm1_nxt_s = qm1_r;
        if (c4 && (op_s == OP_MUL)) begin
            a_nxt_s   = {a_pre_s[WIDTH-1], a_pre_s[WIDTH-1:1]};
            q_nxt_s   = {a_pre_s[0], q_r[WIDTH-1:1]};
            qm1_nxt_s = q_r[0];
        end else if (c4 && (op_s == OP_DIV)) begin
            a_nxt_s   = {a_pre_s[WIDTH-2:0], q_r[WIDTH-1]};
            q_nxt_s   = {q_r[WIDTH-2:0], c6};
        end else begin
            a_nxt_s   = a_pre_s;
        end
        if (c5 && (cnt_r != CNT_MAX)) begin
            cnt_nxt_s = cnt_r + CNT_ONE;
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Datapath registers; c0 loads M and restarts, outbus survives c0 and clears only on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_r    <= '0;
            q_r    <= '0;
            m_r    <= '0;
            qm1_r  <= 1'b0;
            cnt_r  <= '0;
            outbus <= '0;
        end else if (c0) begin
            m_r    <= inbus;
            a_r    <= '0;
            q_r    <= c1 ? inbus : {WIDTH{1'b0}};
            qm1_r  <= 1'b0;
            cnt_r  <= '0;
        end else begin
            a_r    <= a_nxt_s;
            q_r    <= c1 ? inbus : q_nxt_s;
            qm1_r  <= qm1_nxt_s;
            cnt_r  <= cnt_nxt_s;
            if (c7) begin
                outbus <= {a_r, q_r};
            end
        end
    end

    assign q0       = q_r[0];
    assign qm1      = qm1_r;
    assign a7       = a_r[WIDTH-1];
    assign cnt_done = (cnt_r == CNT_MAX);

`ifdef ALU_DP_FLAGS_EN
    // Status flags: c2 reports the adder, c7 reports the captured result (c7 wins if both).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            zf <= 1'b0;
            vf <= 1'b0;
        end else if (c0) begin
            zf <= 1'b0;
            vf <= 1'b0;
        end else begin
            if (c2) begin
                vf <= ovf_s;
                zf <= (sum_s == {WIDTH{1'b0}});
            end
            if (c7) begin
                zf <= ({a_r, q_r} == {(2*WIDTH){1'b0}});
            end
        end
    end
`else
    logic unused_ovf_s;
    assign unused_ovf_s = ovf_s;
`endif

endmodule
